// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared FSM state type and default counter width for period_meter
package period_meter_pkg;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEASURE} state_t;
endpackage

// File: rtl/period_meter_edge_sync.sv
// edge_sync: SYNC_STAGES-deep synchronizer on d plus one delay register for edge detection
// Ports: in_clk clock, reset async active-high, d async input,
//        level synchronized d, rise/fall one-cycle edge strobes on level
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_d;
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_d    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_d    <= r_sync[SYNC_STAGES-1];
        end
    end
    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = level & ~r_d;
    assign fall  = ~level & r_d;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of sig_in in in_clk cycles
// Ports: in_clk clock, reset async active-high, enable run/idle, sig_in measured wave,
//        period/high_time last measurement, valid update pulse, timeout no-rise level flag
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TIMEOUT     = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);
    localparam logic [WIDTH-1:0] LP_TIMEOUT = WIDTH'(TIMEOUT);
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi_lat;
    logic             w_level_unused;
    logic             w_rise;
    logic             w_fall;
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .in_clk (in_clk),
        .reset  (reset),
        .d      (sig_in),
        .level  (w_level_unused),
        .rise   (w_rise),
        .fall   (w_fall)
    );
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi_lat  <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                // dropping enable wins over any edge arriving in the same cycle
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_hi_lat <= '0;
                timeout  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_ARM;
                    ST_ARM: begin
                        if (w_rise) begin
                            r_cnt   <= WIDTH'(1);
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        // an edge landing on the timeout cycle still yields a measurement
                        if (w_rise) begin
                            period    <= r_cnt;
                            high_time <= r_hi_lat;
                            valid     <= 1'b1;
                            timeout   <= 1'b0;
                            r_cnt     <= WIDTH'(1);
                        end else if (r_cnt == LP_TIMEOUT) begin
                            timeout <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_ARM;
                        end else begin
                            r_cnt <= r_cnt + WIDTH'(1);
                            if (w_fall) r_hi_lat <= r_cnt;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter
module tb_period_meter;
    logic        in_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] pa, ha, pb, hb;
    logic        va, ta, vb, tb2;
    int          nvec = 0;
    int          nerr = 0;
    int          s_nv, s_first, s_pmin, s_pmax, s_hmin, s_hmax, s_to_clr;
    bit          s_to_seen;

    always #5 in_clk = ~in_clk;

    period_meter #(.WIDTH(16), .TIMEOUT(100), .SYNC_STAGES(2)) dut_a (
        .in_clk(in_clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .period(pa), .high_time(ha), .valid(va), .timeout(ta)
    );
    period_meter #(.WIDTH(16), .TIMEOUT(8), .SYNC_STAGES(2)) dut_b (
        .in_clk(in_clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .period(pb), .high_time(hb), .valid(vb), .timeout(tb2)
    );

    task automatic tick(input logic v);
        sig_in = v;
        @(posedge in_clk);
        #1;
    endtask

    task automatic flush();
        enable = 1'b0;
        repeat (4) tick(1'b0);
        enable = 1'b1;
        repeat (2) tick(1'b0);
    endtask

    // drives n cycles of a wave starting with its rising edge and gathers observations
    task automatic drive_wave(input int per, input int hi, input int n, input bit use_b);
        logic        v, t;
        logic [15:0] p, h;
        s_nv = 0; s_first = -1; s_to_clr = -1; s_to_seen = 0;
        s_pmin = 65535; s_pmax = 0; s_hmin = 65535; s_hmax = 0;
        for (int c = 0; c < n; c++) begin
            tick(logic'((c % per) < hi));
            v = use_b ? vb : va;
            t = use_b ? tb2 : ta;
            p = use_b ? pb : pa;
            h = use_b ? hb : ha;
            if (v) begin
                s_nv++;
                if (s_first < 0) s_first = c;
                if (int'(p) < s_pmin) s_pmin = int'(p);
                if (int'(p) > s_pmax) s_pmax = int'(p);
                if (int'(h) < s_hmin) s_hmin = int'(h);
                if (int'(h) > s_hmax) s_hmax = int'(h);
            end
            if (t) s_to_seen = 1;
            else if (s_to_clr < 0) s_to_clr = c;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        nvec++; if ({pa, ha, va, ta} !== 34'd0) begin nerr++; $display("FAIL reset_a: got %h want 0", {pa, ha, va, ta}); end
        nvec++; if ({pb, hb, vb, tb2} !== 34'd0) begin nerr++; $display("FAIL reset_b: got %h want 0", {pb, hb, vb, tb2}); end
        reset = 1'b0;
    endtask

    task automatic test_div4();
        flush();
        drive_wave(4, 2, 40, 0);
        nvec++; if (s_nv !== 9) begin nerr++; $display("FAIL div4_count: got %0d want 9", s_nv); end
        nvec++; if (s_first !== 6) begin nerr++; $display("FAIL div4_first: got %0d want 6", s_first); end
        nvec++; if (s_pmin !== 4 || s_pmax !== 4) begin nerr++; $display("FAIL div4_period: got %0d..%0d want 4", s_pmin, s_pmax); end
        nvec++; if (s_hmin !== 2 || s_hmax !== 2) begin nerr++; $display("FAIL div4_high: got %0d..%0d want 2", s_hmin, s_hmax); end
    endtask

    task automatic test_asym();
        flush();
        drive_wave(10, 3, 50, 0);
        nvec++; if (s_nv !== 4) begin nerr++; $display("FAIL asym_count: got %0d want 4", s_nv); end
        nvec++; if (s_first !== 12) begin nerr++; $display("FAIL asym_first: got %0d want 12", s_first); end
        nvec++; if (s_pmin !== 10 || s_pmax !== 10) begin nerr++; $display("FAIL asym_period: got %0d..%0d want 10", s_pmin, s_pmax); end
        nvec++; if (s_hmin !== 3 || s_hmax !== 3) begin nerr++; $display("FAIL asym_high: got %0d..%0d want 3", s_hmin, s_hmax); end
    endtask

    task automatic test_timeout();
        bit early_to = 0, any_v = 0;
        flush();
        // rise at tick 0 loads cnt=1 at tick 2, so timeout lands at tick 102
        for (int c = 0; c < 102; c++) begin
            tick(logic'(c < 2));
            if (ta) early_to = 1;
            if (va) any_v = 1;
        end
        nvec++; if (early_to !== 1'b0) begin nerr++; $display("FAIL to_early: got %b want 0", early_to); end
        tick(1'b0);
        if (va) any_v = 1;
        nvec++; if (ta !== 1'b1) begin nerr++; $display("FAIL to_set: got %b want 1", ta); end
        repeat (5) begin tick(1'b0); if (va) any_v = 1; end
        nvec++; if (ta !== 1'b1) begin nerr++; $display("FAIL to_hold: got %b want 1", ta); end
        nvec++; if (any_v !== 1'b0) begin nerr++; $display("FAIL to_novalid: got %b want 0", any_v); end
        drive_wave(4, 2, 8, 0);
        nvec++; if (s_nv !== 1 || s_first !== 6) begin nerr++; $display("FAIL to_rearm: got %0d valids first %0d want 1 first 6", s_nv, s_first); end
        nvec++; if (s_to_clr !== 6) begin nerr++; $display("FAIL to_clear: got tick %0d want 6", s_to_clr); end
        nvec++; if (s_pmin !== 4 || s_pmax !== 4) begin nerr++; $display("FAIL to_period: got %0d..%0d want 4", s_pmin, s_pmax); end
    endtask

    task automatic test_enable_drop();
        bit bad = 0;
        flush();
        drive_wave(6, 2, 20, 0);
        nvec++; if (s_nv !== 2 || s_pmin !== 6 || s_hmax !== 2) begin nerr++; $display("FAIL en_pre: got %0d valids p %0d h %0d want 2 p 6 h 2", s_nv, s_pmin, s_hmax); end
        enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(logic'(c < 2));
            if (va || ta || pa !== 16'd6 || ha !== 16'd2) bad = 1;
        end
        nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL en_hold: got v %b t %b p %0d h %0d want 0 0 6 2", va, ta, pa, ha); end
        enable = 1'b1;
        drive_wave(5, 2, 16, 0);
        nvec++; if (s_nv !== 2 || s_first !== 7) begin nerr++; $display("FAIL en_rearm: got %0d valids first %0d want 2 first 7", s_nv, s_first); end
        nvec++; if (s_pmin !== 5 || s_pmax !== 5) begin nerr++; $display("FAIL en_period: got %0d..%0d want 5", s_pmin, s_pmax); end
    endtask

    task automatic test_async_reset();
        flush();
        drive_wave(4, 2, 10, 0);
        nvec++; if (pa !== 16'd4) begin nerr++; $display("FAIL ar_pre: got %0d want 4", pa); end
        #3 reset = 1'b1;
        #1;
        nvec++; if ({pa, ha, va, ta} !== 34'd0) begin nerr++; $display("FAIL ar_immediate: got %h want 0", {pa, ha, va, ta}); end
        @(posedge in_clk);
        #1 reset = 1'b0;
        tick(1'b0);
        tick(1'b0);
        drive_wave(4, 2, 12, 0);
        nvec++; if (s_nv !== 2 || s_first !== 6) begin nerr++; $display("FAIL ar_restart: got %0d valids first %0d want 2 first 6", s_nv, s_first); end
        nvec++; if (s_pmin !== 4 || s_hmax !== 2) begin nerr++; $display("FAIL ar_meas: got p %0d h %0d want 4 2", s_pmin, s_hmax); end
    endtask

    task automatic test_collision();
        flush();
        drive_wave(8, 4, 40, 1);
        nvec++; if (s_to_seen !== 1'b0) begin nerr++; $display("FAIL col_timeout: got %b want 0", s_to_seen); end
        nvec++; if (s_nv !== 4 || s_first !== 10) begin nerr++; $display("FAIL col_count: got %0d valids first %0d want 4 first 10", s_nv, s_first); end
        nvec++; if (s_pmin !== 8 || s_pmax !== 8 || s_hmin !== 4) begin nerr++; $display("FAIL col_meas: got p %0d..%0d h %0d want 8 4", s_pmin, s_pmax, s_hmin); end
        drive_wave(8, 4, 20, 1);
        tick(1'b0);
        repeat (12) tick(1'b0);
        nvec++; if (tb2 !== 1'b1) begin nerr++; $display("FAIL col_real_timeout: got %b want 1", tb2); end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_asym();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
